// File: rtl/mod_n_counter_arbiter_if.sv
// Request/load/result bundle between the event sources and the shared mod-N counter.
// The master drives requests and loads; the slave returns acks and results.
interface mod_n_counter_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int SELW    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic               load_en;
  logic [SELW-1:0]    load_sel;
  logic [WIDTH-1:0]   load_val;
  logic [NUM_REQ-1:0] ack;
  logic [SELW-1:0]    ack_idx;
  logic [WIDTH-1:0]   count_out;
  logic               wrap;
  logic               busy;

  modport master (
    output req, load_en, load_sel, load_val,
    input  ack, ack_idx, count_out, wrap, busy
  );

  modport slave (
    input  req, load_en, load_sel, load_val,
    output ack, ack_idx, count_out, wrap, busy
  );
endinterface

// File: rtl/mod_n_counter_arbiter.sv
// Round-robin shared mod-N incrementer over a bank of per-requester counter slots.
// Two-stage pipeline (arbitrate, execute), all state on the falling clock edge.
module mod_n_counter_arbiter #(
  parameter int N       = 256,
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mod_n_counter_arbiter_if.slave bus
);
  localparam int SELW = $clog2(NUM_REQ);

  logic [WIDTH-1:0]   slot [NUM_REQ];
  logic [SELW-1:0]    rr_ptr;
  logic               vld_p1;
  logic [SELW-1:0]    idx_p1;

  logic [NUM_REQ-1:0] inflight_mask;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_vld;
  logic [SELW-1:0]    grant_idx;
  logic [SELW-1:0]    ptr_next;
  logic [WIDTH-1:0]   inc_val;
  logic               collide;
  logic               load_ok;

  // Values at or above N-1 (including out-of-range loads) roll over to zero.
  function automatic logic [WIDTH-1:0] mod_inc(input logic [WIDTH-1:0] v);
    if (v >= WIDTH'(N - 1)) return '0;
    else                    return v + WIDTH'(1);
  endfunction

  always_comb begin
    inflight_mask = '0;
    if (vld_p1) inflight_mask[idx_p1] = 1'b1;
    eligible = bus.req & ~inflight_mask;
  end

  // Circular scan starting at rr_ptr; a load stalls arbitration for the edge.
  always_comb begin
    int               c;
    logic [SELW-1:0]  ci;
    grant_vld = 1'b0;
    grant_idx = '0;
    c         = 0;
    ci        = '0;
    if (!bus.load_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        c  = (int'(rr_ptr) + i) % NUM_REQ;
        ci = SELW'(c);
        if (!grant_vld && eligible[ci]) begin
          grant_vld = 1'b1;
          grant_idx = ci;
        end
      end
    end
    ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + SELW'(1);
  end

  always_comb begin
    inc_val = mod_inc(slot[idx_p1]);
    load_ok = int'(bus.load_sel) < NUM_REQ;
    collide = bus.load_en && load_ok && (bus.load_sel == idx_p1);
  end

  assign bus.busy = vld_p1;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
      rr_ptr        <= '0;
      vld_p1        <= 1'b0;
      idx_p1        <= '0;
      bus.ack       <= '0;
      bus.ack_idx   <= '0;
      bus.count_out <= '0;
      bus.wrap      <= 1'b0;
    end else begin
      // Stage 0 -> 1: register the grant
      vld_p1 <= grant_vld;
      if (grant_vld) begin
        idx_p1 <= grant_idx;
        rr_ptr <= ptr_next;
      end

      // Stage 1 -> result: execute the increment, a colliding load overrides it
      if (vld_p1) begin
        bus.ack     <= NUM_REQ'(1) << idx_p1;
        bus.ack_idx <= idx_p1;
        if (collide) begin
          bus.count_out <= bus.load_val;
          bus.wrap      <= 1'b0;
        end else begin
          slot[idx_p1]  <= inc_val;
          bus.count_out <= inc_val;
          bus.wrap      <= (inc_val == '0);
        end
      end else begin
        bus.ack  <= '0;
        bus.wrap <= 1'b0;
      end

      if (bus.load_en && load_ok) slot[bus.load_sel] <= bus.load_val;
    end
  end
endmodule

// File: tb/tb_mod_n_counter_arbiter.sv
// Directed and randomized bench for mod_n_counter_arbiter against an abstract
// model of the slot bank, round-robin pointer and pending operation.
module tb_mod_n_counter_arbiter;
  localparam int N       = 256;
  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int SELW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mod_n_counter_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .SELW(SELW)) bus ();

  mod_n_counter_arbiter #(.N(N), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint unsigned m_slot [NUM_REQ];
  int              m_ptr;
  bit              m_pend;
  int              m_pidx;
  int              e_ack;
  int              e_idx;
  longint unsigned e_cnt;
  int              e_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) m_slot[i] = 0;
    m_ptr = 0; m_pend = 0; m_pidx = 0;
    e_ack = 0; e_idx = 0; e_cnt = 0; e_wrap = 0;
  endtask

  // One falling edge of behaviour computed from the rules of the block.
  task automatic model_edge();
    bit old_pend;
    int old_idx;
    int win;
    longint unsigned nv;
    old_pend = m_pend;
    old_idx  = m_pidx;
    if (old_pend) begin
      nv = (m_slot[old_idx] >= N - 1) ? 0 : m_slot[old_idx] + 1;
      if (bus.load_en && int'(bus.load_sel) == old_idx) begin
        e_cnt = bus.load_val; e_wrap = 0;
      end else begin
        e_cnt = nv; e_wrap = (nv == 0);
        m_slot[old_idx] = nv;
      end
      e_ack = 1 << old_idx;
      e_idx = old_idx;
    end else begin
      e_ack = 0; e_wrap = 0;
    end
    if (bus.load_en) m_slot[bus.load_sel] = bus.load_val;
    win = -1;
    if (!bus.load_en) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        int c;
        c = (m_ptr + j) % NUM_REQ;
        if (win < 0 && bus.req[c] && !(old_pend && old_idx == c)) win = c;
      end
    end
    if (win >= 0) begin
      m_pend = 1; m_pidx = win; m_ptr = (win + 1) % NUM_REQ;
    end else begin
      m_pend = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ack"},       bus.ack,       e_ack[NUM_REQ-1:0]);
    chk({tag, ".ack_idx"},   bus.ack_idx,   e_idx[SELW-1:0]);
    chk({tag, ".count_out"}, bus.count_out, e_cnt[31:0]);
    chk({tag, ".wrap"},      bus.wrap,      e_wrap[0]);
    chk({tag, ".busy"},      bus.busy,      m_pend);
  endtask

  // Advance one falling edge, update the model, check #1 later.
  task automatic cycle(input string tag);
    @(negedge clk);
    if (!rst) model_reset(); else model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic set_in(input logic [NUM_REQ-1:0] r, input logic le,
                        input logic [SELW-1:0] ls, input logic [WIDTH-1:0] lv);
    bus.req = r; bus.load_en = le; bus.load_sel = ls; bus.load_val = lv;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle("reset");
    cycle("reset");
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    set_in('0, 1'b0, '0, '0);

    // Reset state
    do_reset();

    // Single requester: every-other-cycle acks, count 1,2,3
    set_in(4'b0001, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) cycle("single");
    chk("single.final_count", bus.count_out, 32'd3);
    set_in('0, 1'b0, '0, '0);
    cycle("single_drain");
    cycle("single_idle");

    // Round-robin fairness from fresh reset
    do_reset();
    set_in(4'b1111, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) cycle("rr");
    set_in('0, 1'b0, '0, '0);
    cycle("rr_drain");
    chk("rr.last_idx", bus.ack_idx, 2'd3);
    chk("rr.last_count", bus.count_out, 32'd2);
    cycle("rr_idle");

    // Wrap at N-1
    set_in('0, 1'b1, 2'd2, 32'd254);
    cycle("wrap_load");
    set_in(4'b0100, 1'b0, '0, '0);
    cycle("wrap_g1");
    cycle("wrap_e1");
    chk("wrap.first_count", bus.count_out, 32'd255);
    chk("wrap.first_wrap", bus.wrap, 1'b0);
    cycle("wrap_g2");
    set_in('0, 1'b0, '0, '0);
    cycle("wrap_e2");
    chk("wrap.second_count", bus.count_out, 32'd0);
    chk("wrap.second_wrap", bus.wrap, 1'b1);

    // Out-of-range load
    set_in('0, 1'b1, 2'd1, 32'd1000);
    cycle("oor_load");
    set_in(4'b0010, 1'b0, '0, '0);
    cycle("oor_grant");
    set_in('0, 1'b0, '0, '0);
    cycle("oor_exec");
    chk("oor.count", bus.count_out, 32'd0);
    chk("oor.wrap", bus.wrap, 1'b1);
    cycle("oor_idle");

    // Load collides with the executing slot
    set_in(4'b1000, 1'b0, '0, '0);
    cycle("col_grant");
    set_in(4'b1000, 1'b1, 2'd3, 32'd77);
    cycle("col_exec");
    chk("col.ack", bus.ack, 4'b1000);
    chk("col.count", bus.count_out, 32'd77);
    chk("col.busy_no_grant", bus.busy, 1'b0);
    set_in(4'b1000, 1'b0, '0, '0);
    cycle("col_regrant");
    set_in('0, 1'b0, '0, '0);
    cycle("col_after");
    chk("col.after_count", bus.count_out, 32'd78);

    // Asynchronous reset in the middle of an operation
    set_in(4'b0001, 1'b0, '0, '0);
    cycle("ar_grant");
    chk("ar.busy_before", bus.busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("ar.busy_now", bus.busy, 1'b0);
    chk("ar.ack_now", bus.ack, 4'b0000);
    chk("ar.count_now", bus.count_out, 32'd0);
    cycle("ar_held");
    rst = 1'b1;
    set_in('0, 1'b0, '0, '0);
    cycle("ar_release");
    // Each slot should increment from zero to one
    for (int s = 0; s < NUM_REQ; s++) begin
      set_in(4'(1 << s), 1'b0, '0, '0);
      cycle("ar_probe_g");
      set_in('0, 1'b0, '0, '0);
      cycle("ar_probe_e");
      chk("ar.probe_count", bus.count_out, 32'd1);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] v;
      case ($urandom_range(0, 5))
        0:       v = 32'd254;
        1:       v = 32'd255;
        2:       v = 32'd256 + $urandom_range(0, 2000);
        3:       v = $urandom;
        default: v = $urandom_range(0, 253);
      endcase
      set_in(4'($urandom), ($urandom_range(0, 5) == 0), 2'($urandom), v);
      cycle("rand");
    end
    set_in('0, 1'b0, '0, '0);
    cycle("rand_drain");
    cycle("rand_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mod_n_counter_arbiter.md
Name: mod_n_counter_arbiter

Overview:
- Shares one mod-N increment datapath among NUM_REQ requesters, each owning a private WIDTH-bit counter slot in a local register bank.
- A round-robin arbiter picks one requester per cycle; the selected slot is read, incremented modulo N, and written back.
- The result and an ack are returned to the winning requester.
- A load port lets the system controller configure any slot directly.
- Sits between per-channel event sources and the shared counter logic in the falling-edge-clocked domain.

Parameters:
- N, 256: modulus; a slot counts 0..N-1.
- WIDTH, 32: counter/slot width; N-1 must fit in WIDTH.
- NUM_REQ, 4: number of requesters (2..16).
- SELW, $clog2(NUM_REQ): slot index width (local).

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately.
- req  input  NUM_REQ  level increment request, one bit per requester.
- load_en  input  1  write load_val into slot load_sel on this edge.
- load_sel  input  SELW  slot index for load.
- load_val  input  WIDTH  value to load; out-of-range values are allowed.
- ack  output  NUM_REQ  one-cycle pulse to the requester whose increment completed.
- ack_idx  output  SELW  index of the completed slot; valid when |ack.
- count_out  output  WIDTH  new slot value; valid when |ack.
- wrap  output  1  pulses with ack when the slot went from >=N-1 to 0.
- busy  output  1  an increment is in flight (stage-1 valid).

Behaviour:
- Reset (rst=0, async): all slots=0, rr_ptr=0, stage-1 valid=0, ack=0, ack_idx=0, count_out=0, wrap=0, busy=0. Reset mid-operation discards the in-flight op; no ack is issued.
- Pipeline: two stages, all on the falling edge of clk.
  - Edge k (arbitrate): eligible = req & ~inflight_mask, where inflight_mask is the one-hot bit of the stage-1 index when stage-1 is valid.
  - If load_en=1, no grant is made this edge (load stalls arbitration).
  - Otherwise the first eligible bit at or after rr_ptr (circular scan) wins. Stage-1 registers valid=1 and idx=winner. rr_ptr becomes winner+1 mod NUM_REQ.
  - If no bit is eligible: valid=0 and rr_ptr is unchanged.
  - Edge k+1 (execute): new = (slot[idx] >= N-1) ? 0 : slot[idx]+1, using WIDTH-bit arithmetic.
  - At execute: slot[idx] <= new; ack[idx]=1 for exactly one cycle; ack_idx=idx; count_out=new; wrap=(new==0).
- Latency: ack pulses one falling edge after grant, i.e. two edges after req is sampled.
- Throughput: one increment per cycle overall. A single requester holding req gets at most one op per 2 cycles, because its own in-flight op blocks it.
- req is level-sensitive. A requester holding req high is re-granted each time it becomes eligible. Dropping req after grant does not cancel the op.
- When not acking, ack=0 and wrap=0; count_out and ack_idx hold their last values.
- Load: slot[load_sel] <= load_val on the edge.
  - Load into a slot with no op in flight: no ack.
  - Load into the slot currently being executed: load wins. ack still pulses, count_out=load_val, wrap=0, and the increment is discarded.
  - Load to a different slot than the one executing: both updates take effect.
- Out-of-range slot value (>= N): the next increment yields 0 with wrap=1.
- busy = stage-1 valid.

Test Plan:
- Reset/basic: release rst, hold req=4'b0001 for 6 cycles → acks on ack[0] every other cycle with count_out 1,2,3; busy toggles 1/0; slot0=3.
- Round-robin fairness: req=4'b1111 held for 8 cycles after reset → grant order 0,1,2,3,0,1,2,3, one ack per cycle from the second edge on, each count_out 1 then 2.
- Wrap: load slot2=254 (N=256), then req[2] for two ops → count_out 255 (wrap=0), then 0 (wrap=1).
- Out-of-range load: load slot1=1000, one req[1] op → count_out=0, wrap=1.
- Load collision: grant slot3 at edge k, assert load_en with load_sel=3 and load_val=77 at edge k+1 → ack[3]=1, count_out=77, wrap=0; slot3 reads 77 afterwards; no grant occurs on edge k+1.
- Async reset mid-op: grant slot0, drop rst low between edges → ack stays 0, busy=0 immediately, all slots read 0 after release.
